// File: rtl/memory_port_pkg.sv
// Shared types and constants for the dual-bank (even/odd byte) memory access unit.
package memory_port_pkg;

    localparam int BANK_AW = 15;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        WORD = 2'd1,
        LONG = 2'd2,
        RSVD = 2'd3
    } size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } state_t;

endpackage

// File: rtl/memory_port_lane.sv
// Maps one beat (a byte pair starting at base_addr) onto the even/odd banks,
// applying ROM write protection per lane and reporting the read-steering select.
module memory_port_lane
    import memory_port_pkg::*;
#(
    parameter logic [15:0] ROMBASE = 16'h4000
) (
    input  logic [15:0]        base_addr,
    input  logic [15:0]        wdata,
    input  logic [1:0]         lane_en,
    input  logic               write,
    output logic [BANK_AW-1:0] addr_even,
    output logic [BANK_AW-1:0] addr_odd,
    output logic [7:0]         data_even,
    output logic [7:0]         data_odd,
    output logic               we_even,
    output logic               we_odd,
    output logic               rom_hit,
    output logic               swap
);

    logic [15:0] addr_hi;
    logic [1:0]  protect;
    logic [1:0]  wr_lane;
    logic [1:0]  we_lane;

    // Lane 0 is the byte at base_addr, lane 1 the byte after it (wrapping at 16 bits).
    always_comb begin
        addr_hi    = base_addr + 16'd1;
        protect[0] = (base_addr >= ROMBASE);
        protect[1] = (addr_hi >= ROMBASE);
        wr_lane    = {2{write}} & lane_en;
        we_lane    = wr_lane & ~protect;
        rom_hit    = |(wr_lane & protect);
        swap       = base_addr[0];

        if (!swap) begin
            addr_even = base_addr[15:1];
            addr_odd  = addr_hi[15:1];
            data_even = wdata[7:0];
            data_odd  = wdata[15:8];
            we_even   = we_lane[0];
            we_odd    = we_lane[1];
        end else begin
            addr_odd  = base_addr[15:1];
            addr_even = addr_hi[15:1];
            data_odd  = wdata[7:0];
            data_even = wdata[15:8];
            we_odd    = we_lane[0];
            we_even   = we_lane[1];
        end
    end

endmodule

// File: rtl/memory_port.sv
// Requester-side access unit: splits byte/word/long requests into per-bank beats,
// steers returned bytes into little-endian order and issues one response per request.
module memory_port
    import memory_port_pkg::*;
#(
    parameter logic [15:0] ROMBASE = 16'h4000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic [15:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_fault,
    output logic [BANK_AW-1:0] read_addr_even,
    output logic [BANK_AW-1:0] read_addr_odd,
    input  logic [7:0]         read_data_even,
    input  logic [7:0]         read_data_odd,
    output logic [BANK_AW-1:0] write_addr_even,
    output logic [BANK_AW-1:0] write_addr_odd,
    output logic [7:0]         write_data_even,
    output logic [7:0]         write_data_odd,
    output logic               write_en_even,
    output logic               write_en_odd
);

    state_t state, next_state;
    size_t  req_kind, resp_size;

    logic [15:0] b2_addr, b2_wdata, last_addr, hold;
    logic        b2_write;
    logic [15:0] lane_base, lane_wdata, steered;
    logic        lane_write, accept;
    logic [1:0]  lane_en;
    logic        resp_write, resp_swap, fault_acc;
    logic [BANK_AW-1:0] bank_addr_even, bank_addr_odd;
    logic        lane_rom_hit, lane_swap;

    memory_port_lane #(.ROMBASE(ROMBASE)) u_lane (
        .base_addr (lane_base),
        .wdata     (lane_wdata),
        .lane_en   (lane_en),
        .write     (lane_write),
        .addr_even (bank_addr_even),
        .addr_odd  (bank_addr_odd),
        .data_even (write_data_even),
        .data_odd  (write_data_odd),
        .we_even   (write_en_even),
        .we_odd    (write_en_odd),
        .rom_hit   (lane_rom_hit),
        .swap      (lane_swap)
    );

    assign read_addr_even  = bank_addr_even;
    assign read_addr_odd   = bank_addr_odd;
    assign write_addr_even = bank_addr_even;
    assign write_addr_odd  = bank_addr_odd;

    // Lane source: live request in IDLE, registered upper half in BEAT2, last address when quiet.
    always_comb begin
        req_kind   = size_t'(req_size);
        req_ready  = reset_n && (state == IDLE);
        accept     = req_valid && req_ready;
        next_state = state;
        lane_base  = last_addr;
        lane_wdata = req_wdata[15:0];
        lane_write = req_write;
        lane_en    = 2'b00;

        case (state)
            IDLE: begin
                if (req_valid) lane_base = req_addr;
                if (accept) begin
                    case (req_kind)
                        BYTE:      lane_en = 2'b01;
                        WORD, LONG: lane_en = 2'b11;
                        default:   lane_en = 2'b00;
                    endcase
                    if (req_kind == LONG) next_state = BEAT2;
                end
            end
            BEAT2: begin
                lane_base  = b2_addr;
                lane_wdata = b2_wdata;
                lane_write = b2_write;
                lane_en    = 2'b11;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        steered    = resp_swap ? {read_data_even, read_data_odd} : {read_data_odd, read_data_even};
        resp_rdata = 32'h0;
        if (resp_valid && !resp_write) begin
            case (resp_size)
                BYTE:    resp_rdata = {24'h0, steered[7:0]};
                WORD:    resp_rdata = {16'h0, steered};
                LONG:    resp_rdata = {steered, hold};
                default: resp_rdata = 32'h0;
            endcase
        end
        resp_fault = resp_valid && fault_acc;
    end

    // Fault accumulates across both beats of a long so one response reports either beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            b2_addr    <= 16'h0;
            b2_wdata   <= 16'h0;
            b2_write   <= 1'b0;
            last_addr  <= 16'h0;
            hold       <= 16'h0;
            resp_valid <= 1'b0;
            resp_size  <= BYTE;
            resp_write <= 1'b0;
            resp_swap  <= 1'b0;
            fault_acc  <= 1'b0;
        end else begin
            state      <= next_state;
            last_addr  <= lane_base;
            resp_valid <= 1'b0;
            if (state == BEAT2) begin
                hold       <= steered;
                resp_swap  <= lane_swap;
                fault_acc  <= fault_acc | lane_rom_hit;
                resp_valid <= 1'b1;
            end else if (accept) begin
                resp_size  <= req_kind;
                resp_write <= req_write;
                resp_swap  <= lane_swap;
                fault_acc  <= (req_kind == RSVD) | lane_rom_hit;
                resp_valid <= (req_kind != LONG);
                b2_addr    <= req_addr + 16'd2;
                b2_write   <= req_write;
                b2_wdata   <= req_wdata[31:16];
            end
        end
    end

endmodule

// File: tb/tb_memory_port.sv
// Self-checking bench for memory_port: directed scenarios plus randomized traffic
// checked against a flat byte-addressed memory model.
module tb_memory_port;

    localparam logic [15:0] ROMBASE = 16'h4000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
    logic [7:0]  read_data_even, read_data_odd, write_data_even, write_data_odd;
    logic        write_en_even, write_en_odd;

    logic [7:0]  mem_even [32768];
    logic [7:0]  mem_odd  [32768];
    logic [7:0]  ref_mem  [65536];
    logic        init_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;

    logic [14:0] b1_ra_even, b1_ra_odd, b2_ra_even, b2_ra_odd;
    logic [1:0]  b1_we;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    memory_port #(.ROMBASE(ROMBASE)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .read_addr_even  (read_addr_even),
        .read_addr_odd   (read_addr_odd),
        .read_data_even  (read_data_even),
        .read_data_odd   (read_data_odd),
        .write_addr_even (write_addr_even),
        .write_addr_odd  (write_addr_odd),
        .write_data_even (write_data_even),
        .write_data_odd  (write_data_odd),
        .write_en_even   (write_en_even),
        .write_en_odd    (write_en_odd)
    );

    // Bank memories: synchronous read, one cycle latency; also loaded from the model on request.
    always @(posedge clk) begin
        read_data_even <= mem_even[read_addr_even];
        read_data_odd  <= mem_odd[read_addr_odd];
        if (write_en_even) mem_even[write_addr_even] <= write_data_even;
        if (write_en_odd)  mem_odd[write_addr_odd]   <= write_data_odd;
        if (init_en) begin
            for (int i = 0; i < 32768; i++) begin
                mem_even[i] <= ref_mem[2*i];
                mem_odd[i]  <= ref_mem[2*i+1];
            end
        end
        if (poke_en) begin
            if (poke_addr[0]) mem_odd[poke_addr[15:1]]  <= ref_mem[poke_addr];
            else              mem_even[poke_addr[15:1]] <= ref_mem[poke_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        @(negedge clk);
        poke_addr = a;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // One complete transaction; expected results come from the byte-level model.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                                 input logic [31:0] wd);
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [15:0] a;
        int          nbytes;
        exp_data  = 32'h0;
        exp_fault = (sz == 2'd3);
        nbytes    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 16'(k);
            if (wr) begin
                if (a >= ROMBASE) exp_fault = 1'b1;
                else ref_mem[a] = wd[8*k +: 8];
            end else begin
                exp_data[8*k +: 8] = ref_mem[a];
            end
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        b1_ra_even = read_addr_even;
        b1_ra_odd  = read_addr_odd;
        b1_we      = {write_en_even, write_en_odd};
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (sz == 2'd2) begin
            checkOutput("req_ready_beat2", 32'(req_ready), 32'd0);
            checkOutput("resp_valid_beat2", 32'(resp_valid), 32'd0);
            b2_ra_even = read_addr_even;
            b2_ra_odd  = read_addr_odd;
            @(posedge clk);
            #1;
        end
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, exp_data);
        checkOutput("resp_fault", 32'(resp_fault), 32'(exp_fault));
    endtask

    initial begin
        logic [15:0] ra;
        int          sel;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = 16'h0;
        req_wdata = 32'h0;

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
        @(negedge clk);
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;

        // Reset behaviour
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd1;
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_write_en", 32'({write_en_even, write_en_odd}), 32'd0);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_resp_fault", 32'(resp_fault), 32'd0);
        req_valid = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

        // Word read at odd address 0x0123
        poke(16'h0123, 8'h34);
        poke(16'h0124, 8'h12);
        applyStimulus(1'b0, 2'd1, 16'h0123, 32'h0);
        checkOutput("word_rd_addr_odd", 32'(b1_ra_odd), 32'h091);
        checkOutput("word_rd_addr_even", 32'(b1_ra_even), 32'h092);
        checkOutput("word_rd_value", resp_rdata, 32'h0000_1234);

        // Long write at 0x0200
        applyStimulus(1'b1, 2'd2, 16'h0200, 32'hDDCC_BBAA);
        @(negedge clk);
        checkOutput("long_wr_even100", 32'(mem_even[15'h100]), 32'hAA);
        checkOutput("long_wr_odd100", 32'(mem_odd[15'h100]), 32'hBB);
        checkOutput("long_wr_even101", 32'(mem_even[15'h101]), 32'hCC);
        checkOutput("long_wr_odd101", 32'(mem_odd[15'h101]), 32'hDD);

        // Long read wrapping at 0xFFFF
        applyStimulus(1'b0, 2'd2, 16'hFFFF, 32'h0);
        checkOutput("wrap_b1_odd", 32'(b1_ra_odd), 32'h7FFF);
        checkOutput("wrap_b1_even", 32'(b1_ra_even), 32'h0000);
        checkOutput("wrap_b2_odd", 32'(b2_ra_odd), 32'h0000);
        checkOutput("wrap_b2_even", 32'(b2_ra_even), 32'h0001);

        // Word write straddling the ROM boundary
        applyStimulus(1'b1, 2'd1, 16'h3FFF, 32'h0000_5566);
        checkOutput("rom_strobes", 32'(b1_we), 32'd1);
        @(negedge clk);
        checkOutput("rom_odd_written", 32'(mem_odd[15'h1FFF]), 32'h66);
        checkOutput("rom_even_kept", 32'(mem_even[15'h2000]), 32'(ref_mem[16'h4000]));

        // Reserved size
        applyStimulus(1'b1, 2'd3, 16'h0040, 32'hFFFF_FFFF);
        checkOutput("rsvd_no_strobe", 32'(b1_we), 32'd0);

        // Back-to-back byte reads
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("b2b_ready", 32'(req_ready), 32'd1);
            checkOutput("b2b_valid", 32'(resp_valid), 32'd1);
            checkOutput("b2b_rdata", resp_rdata, {24'h0, ref_mem[16'h0010 + 16'(i)]});
            if (i < 2) req_addr = 16'h0011 + 16'(i);
            else req_valid = 1'b0;
        end

        // Reset during BEAT2 of a long write
        poke(16'h0302, 8'h00);
        poke(16'h0303, 8'h00);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 16'h0300;
        req_wdata = 32'h4433_2211;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        checkOutput("abort_write_en", 32'({write_en_even, write_en_odd}), 32'd0);
        checkOutput("abort_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("abort_ready_high", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort_no_resp2", 32'(resp_valid), 32'd0);
        ref_mem[16'h0300] = 8'h11;
        ref_mem[16'h0301] = 8'h22;
        checkOutput("abort_b1_even", 32'(mem_even[15'h180]), 32'h11);
        checkOutput("abort_b1_odd", 32'(mem_odd[15'h180]), 32'h22);
        checkOutput("abort_b2_even", 32'(mem_even[15'h181]), 32'h00);
        checkOutput("abort_b2_odd", 32'(mem_odd[15'h181]), 32'h00);

        // Randomized traffic concentrated near the ROM boundary and the wrap point
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ra = 16'($urandom);
                1:       ra = ROMBASE - 16'd4 + 16'($urandom_range(0, 7));
                2:       ra = 16'hFFFC + 16'($urandom_range(0, 7));
                default: ra = 16'($urandom_range(0, 255));
            endcase
            applyStimulus(1'($urandom), 2'($urandom), ra, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/memory_port.md
# memory_port

Requester-side access unit for the dual-bank (even/odd byte) synchronous memory. It accepts byte, word and long transactions on a 16-bit byte address from the core, then splits each into per-bank 15-bit addresses and write strobes. It steers returned bytes back into little-endian order and returns one response per request. It sits between the f8 core's load/store path and the memory subsystem, and also enforces ROM write protection.

## Interface
Parameters:
- ROMBASE, 16'h4000: first byte address of ROM. Must be even. Byte writes at addresses ≥ ROMBASE are suppressed.

Ports:
- clk  in  1  sole clock; everything is sampled on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clock edge.
- req_write  in  1  1 = write, 0 = read.
- req_size  in  2  0 = byte, 1 = word (2 bytes), 2 = long (4 bytes), 3 = reserved.
- req_addr  in  16  byte address of the least significant byte.
- req_wdata  in  32  write data, little-endian; unused upper bytes are ignored.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read data, zero-extended; 0 for writes.
- resp_fault  out  1  valid with resp_valid: reserved size, or at least one ROM byte write was suppressed.
- read_addr_even / read_addr_odd  out  15  bank read addresses.
- read_data_even / read_data_odd  in  8  bank read data, one cycle after the address.
- write_addr_even / write_addr_odd  out  15  bank write addresses.
- write_data_even / write_data_odd  out  8  bank write data.
- write_en_even / write_en_odd  out  1  bank write strobes.

## Operation
- **Byte k of a transaction** lives at address (req_addr + k) mod 2^16. Bank select is address bit 0 (0 = even). The bank address is bits [15:1]. Wrap-around from FFFF to 0000 is silent.
- **Beats.** A beat covers one byte pair (A, A+1), so any alignment uses each bank at most once per beat.
  - Byte and word requests take one beat.
  - Long requests take two beats: beat 1 covers A and A+1, beat 2 covers A+2 and A+3.
  - In a byte request only the lane of A is enabled.
- **States.**
  - IDLE: req_ready = 1. An accepted long request moves to BEAT2. Any other accepted request stays in IDLE.
  - BEAT2: req_ready = 0. Drives beat-2 addresses and data from registered copies of the address, write flag and wdata[31:16]. Always returns to IDLE on the next clock edge.
- **Read steering.** The lane holding byte A of a beat maps to the lower byte of that beat's half, and the other lane to the upper byte.
  - Beat-1 data of a long read is captured into a holding register at the end of BEAT2.
  - resp_rdata = {beat-2 steered, holding} for long, {8'h0, 8'h0, steered} for word, {24'h0, byte} for byte.
- **ROM protection.** The write strobe of any byte lane with address ≥ ROMBASE is forced to 0, and the fault flag for the response is set. The other lanes of the same request still write.
- **Reserved size.** The request is accepted with no bank strobes. The unit responds with resp_fault = 1 and resp_rdata = 0.
- **Idle bank outputs.** When not in an accepted beat, write_en_* = 0. Read addresses are don't-care but held stable.

## Timing
- **Byte/word accepted at edge N.**
  - Bank addresses and strobes are driven combinationally during the cycle preceding edge N (from the req_* inputs).
  - resp_valid = 1 in cycle N+1. resp_rdata is steered combinationally from read_data_*.
  - Throughput is one request per cycle; back-to-back requests are allowed.
- **Long accepted at edge N.**
  - Beat 2 is driven in cycle N+1.
  - resp_valid = 1 in cycle N+2.
  - req_ready = 0 during cycle N+1.
- **Writes.** The strobe occurs in the beat cycle. resp_valid follows on the same schedule as reads.
- **Reset values.** state = IDLE; resp_valid = 0; resp_fault = 0; holding register = 0. req_ready = 1 once reset is released. While reset_n = 0, req_ready = 0 and write_en_* = 0.
- **Reset mid-transaction.** Asserting reset_n in BEAT2 aborts the transaction: no beat-2 write and no response.

## Structure
- Package memory_port_pkg holds:
  - the size_t enum (BYTE, WORD, LONG, RSVD);
  - the state_t enum (IDLE, BEAT2);
  - the BANK_AW = 15 constant.
- One sub-module, memory_port_lane: given a beat base address, write data, enable mask and ROMBASE, it produces both banks' address, data and strobe plus the read-steering select. It is instantiated once and fed from either the request or the BEAT2 registers.

## Test plan
- Word read at 0x0123 (odd) with odd bank[0x0091] = 0x34 and even bank[0x0092] = 0x12 -> read_addr_odd = 0x091, read_addr_even = 0x092, next cycle resp_rdata = 0x00001234, resp_fault = 0.
- Long write of 0xDDCCBBAA at 0x0200 -> beat 1: even[0x100] = AA, odd[0x100] = BB; beat 2: even[0x101] = CC, odd[0x101] = DD; req_ready = 0 in beat 2; resp_valid two cycles after acceptance.
- Long read at 0xFFFF -> bytes come from FFFF, 0000, 0001, 0002 (bank addresses 0x7FFF odd, 0x0000 even, then 0x0000 odd, 0x0001 even), correctly ordered in resp_rdata.
- Word write 0x5566 at 0x3FFF with ROMBASE = 0x4000 -> only odd[0x1FFF] = 0x66 is written, write_en_even stays 0, resp_fault = 1.
- Back-to-back byte reads to 0x0010, 0x0011, 0x0012 on consecutive cycles -> three consecutive resp_valid pulses with the correct bytes; req_ready stays 1.
- reset_n asserted during BEAT2 of a long write -> no beat-2 strobe, no resp_valid, state IDLE, req_ready = 1 after release.
